// File: rtl/reg_file_wb.sv
// Register-file write-back stage of the multicycle MIPS datapath: 2**ADDR_W GPRs,
// two combinational read ports and a two-cycle valid/ready write-back path.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit FWD    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [1:0]        wb_sel,
  input  logic [1:0]        wb_dst_sel,
  input  logic [ADDR_W-1:0] wb_rt,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_pc,
  output logic              wb_done,
  output logic              wb_err
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LINK_REG = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              pend_ill_q, pend_ill_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic [ADDR_W-1:0] dst_addr_s;
  logic [DATA_W-1:0] src_data_s;
  logic              sel_ill_s;
  logic              wr_en_s;
  logic              hit_a_s;
  logic              hit_b_s;

  // Source and destination decode of the request currently on the inputs.
  always_comb begin
    dst_addr_s = ZERO_REG;
    src_data_s = ZERO_DATA;
    sel_ill_s  = 1'b0;
    case (wb_dst_sel)
      2'd0:    dst_addr_s = wb_rt;
      2'd1:    dst_addr_s = wb_rd;
      2'd2:    dst_addr_s = LINK_REG;
      default: begin
        dst_addr_s = ZERO_REG;
        sel_ill_s  = 1'b1;
      end
    endcase
    case (wb_sel)
      2'd0:    src_data_s = alu_out;
      2'd1:    src_data_s = mem_data;
      2'd2:    src_data_s = link_pc;
      default: begin
        src_data_s = ZERO_DATA;
        sel_ill_s  = 1'b1;
      end
    endcase
  end

  assign wr_en_s = (state_q == ST_WRITE) && !pend_ill_q && (pend_addr_q != ZERO_REG);

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_ill_d  = pend_ill_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_valid) begin
          pend_addr_d = dst_addr_s;
          pend_data_d = src_data_s;
          pend_ill_d  = sel_ill_s;
          state_d     = ST_WRITE;
          ready_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_WRITE: begin
        // wb_valid is deliberately ignored here: one commit per two cycles.
        done_d  = 1'b1;
        err_d   = pend_ill_q;
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = (wr_en_s && (pend_addr_q == ADDR_W'(i))) ? pend_data_q : regs_q[i];
    end
    regs_d[0] = ZERO_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= ZERO_REG;
      pend_data_q <= ZERO_DATA;
      pend_ill_q  <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= ZERO_DATA;
      end
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_ill_q  <= pend_ill_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Bypass only a write that will actually land in the array.
  assign hit_a_s = FWD && wr_en_s && (rs_addr == pend_addr_q);
  assign hit_b_s = FWD && wr_en_s && (rt_addr == pend_addr_q);

  assign rd_data_a = (rs_addr == ZERO_REG) ? ZERO_DATA :
                     hit_a_s               ? pend_data_q : regs_q[rs_addr];
  assign rd_data_b = (rt_addr == ZERO_REG) ? ZERO_DATA :
                     hit_b_s               ? pend_data_q : regs_q[rt_addr];

  assign wb_ready = ready_q;
  assign wb_done  = done_q;
  assign wb_err   = err_q;

endmodule
